// File: rtl/gray_ptr_sync_mon.sv
// Gray-coded pointer synchroniser with a registered monitor stage: binary view,
// change pulse, modular step count and a sticky multi-bit-change error flag.
module gray_ptr_sync_mon #(
    parameter int ADDRSIZE = 4,
    parameter int STAGES   = 2,
    parameter int CHECK_EN = 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [ADDRSIZE:0]   ptr,
    input  logic                err_clr,
    output logic [ADDRSIZE:0]   q_ptr,
    output logic [ADDRSIZE:0]   q_bin,
    output logic                upd,
    output logic [ADDRSIZE:0]   step,
    output logic                err
);

    localparam int W = ADDRSIZE + 1;

    if (STAGES < 2 || STAGES > 4) begin : g_stages_bad
        $error("gray_ptr_sync_mon: STAGES must be in the range 2..4");
    end

    function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // True when more than one bit is set: clearing the lowest set bit leaves something.
    function automatic logic multi_bit(input logic [W-1:0] x);
        return (x & (x - 1'b1)) != '0;
    endfunction

    logic [STAGES-1:0][W-1:0] sync_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], ptr};
        end
    end

    assign q_ptr = sync_q[STAGES-1];

    logic [W-1:0] prev_q, q_bin_q, step_q;
    logic         upd_q, err_q;
    logic [W-1:0] bin_d, prev_bin, step_d;
    logic         upd_d, viol, err_d;

    always_comb begin
        bin_d    = gray2bin(q_ptr);
        prev_bin = gray2bin(prev_q);
        upd_d    = (q_ptr != prev_q);
        step_d   = bin_d - prev_bin;
        viol     = (CHECK_EN != 0) && multi_bit(q_ptr ^ prev_q);
        // A fresh violation outranks a clear request on the same edge.
        err_d    = viol | (err_q & ~err_clr);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            prev_q  <= '0;
            q_bin_q <= '0;
            upd_q   <= 1'b0;
            step_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            prev_q  <= q_ptr;
            q_bin_q <= bin_d;
            upd_q   <= upd_d;
            step_q  <= step_d;
            err_q   <= err_d;
        end
    end

    assign q_bin = q_bin_q;
    assign upd   = upd_q;
    assign step  = step_q;
    assign err   = err_q;

endmodule

// File: tb/tb_gray_ptr_sync_mon.sv
// Scoreboard bench for gray_ptr_sync_mon: three instances (STAGES=2, STAGES=3,
// CHECK_EN=0) share one stimulus stream and each has its own expectation queues.
module tb_gray_ptr_sync_mon;

    localparam int AW = 4;
    localparam int W  = AW + 1;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         err_clr = 1'b0;
    logic [W-1:0] ptr = '0;

    int nchk = 0;
    int nerr = 0;

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [W-1:0] g;
        logic [W-1:0] bin;
        logic         upd;
        logic [W-1:0] step;
        logic         viol;
    } ent_t;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Binary from Gray as the XOR of all right shifts of the code.
    function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
        logic [W-1:0] b;
        b = g;
        for (int s = 1; s < W; s++) b = b ^ (g >> s);
        return b;
    endfunction

    function automatic logic [W-1:0] b2g(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int S  = (gi == 1) ? 3 : 2;
        localparam int CE = (gi == 2) ? 0 : 1;

        logic [W-1:0] q_ptr, q_bin, step;
        logic         upd, err;

        gray_ptr_sync_mon #(
            .ADDRSIZE(AW),
            .STAGES  (S),
            .CHECK_EN(CE)
        ) u_dut (
            .CLK    (CLK),
            .RST    (RST),
            .ptr    (ptr),
            .err_clr(err_clr),
            .q_ptr  (q_ptr),
            .q_bin  (q_bin),
            .upd    (upd),
            .step   (step),
            .err    (err)
        );

        ent_t         qp[$];
        ent_t         qm[$];
        logic [W-1:0] last_g = '0;
        logic         clr_s  = 1'b0;
        logic         err_m  = 1'b0;

        function automatic ent_t mk(input logic [W-1:0] g, input logic [W-1:0] p);
            ent_t e;
            e.g    = g;
            e.bin  = g2b(g);
            e.upd  = (g != p);
            e.step = g2b(g) - g2b(p);
            e.viol = (CE != 0) && ($countones(g ^ p) > 1);
            return e;
        endfunction

        // Reset empties the pipeline: S-1 zero stages are already in flight.
        always @(posedge RST) begin
            qp.delete();
            qm.delete();
            for (int i = 0; i < S - 1; i++) qp.push_back(mk('0, '0));
            last_g = '0;
            err_m  = 1'b0;
            #1;
            check($sformatf("S%0d/CE%0d async q_ptr", S, CE), 32'(q_ptr), 32'd0);
            check($sformatf("S%0d/CE%0d async q_bin", S, CE), 32'(q_bin), 32'd0);
            check($sformatf("S%0d/CE%0d async upd", S, CE), 32'(upd), 32'd0);
            check($sformatf("S%0d/CE%0d async step", S, CE), 32'(step), 32'd0);
            check($sformatf("S%0d/CE%0d async err", S, CE), 32'(err), 32'd0);
        end

        always @(posedge CLK) begin : b_push
            logic [W-1:0] g;
            g = RST ? '0 : ptr;
            qp.push_back(mk(g, last_g));
            last_g = g;
            clr_s  = err_clr;
        end

        always @(negedge CLK) begin : b_chk
            ent_t e;
            if (qm.size() > 0) begin
                e = qm.pop_front();
                err_m = e.viol | (err_m & ~clr_s);
                check($sformatf("S%0d/CE%0d q_bin", S, CE), 32'(q_bin), 32'(e.bin));
                check($sformatf("S%0d/CE%0d upd", S, CE), 32'(upd), 32'(e.upd));
                check($sformatf("S%0d/CE%0d step", S, CE), 32'(step), 32'(e.step));
                check($sformatf("S%0d/CE%0d err", S, CE), 32'(err), 32'(err_m));
            end
            if (qp.size() >= S) begin
                e = qp.pop_front();
                check($sformatf("S%0d/CE%0d q_ptr", S, CE), 32'(q_ptr), 32'(e.g));
                qm.push_back(e);
            end
        end
    end

    initial begin
        logic [W-1:0] b;

        // Reset with a busy pointer on the input, asserted before any clock edge.
        ptr = 5'b10110;
        #1 RST = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        ptr = 5'b00001;
        repeat (4) @(negedge CLK);

        // Full Gray count including the wrap back to zero.
        for (int i = 0; i < 32; i++) begin
            ptr = b2g(W'(i));
            @(negedge CLK);
        end
        ptr = '0;
        repeat (5) @(negedge CLK);

        // Two-bit jump, long idle, then a single clear pulse.
        ptr = 5'b00011;
        repeat (12) @(negedge CLK);
        err_clr = 1'b1;
        @(negedge CLK);
        err_clr = 1'b0;
        repeat (3) @(negedge CLK);

        // Second jump with clear held over both instances' monitor edges.
        ptr = 5'b01100;
        repeat (2) @(negedge CLK);
        err_clr = 1'b1;
        repeat (2) @(negedge CLK);
        err_clr = 1'b0;
        repeat (4) @(negedge CLK);

        // Reset in the middle of a count sitting at 9.
        ptr = 5'b01101;
        repeat (5) @(negedge CLK);
        #2 RST = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        repeat (6) @(negedge CLK);

        // Random legal walk: hold, step up or step down by one code.
        b = 5'd9;
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 2))
                0: b = b + 1'b1;
                1: b = b - 1'b1;
                default: b = b;
            endcase
            ptr = b2g(b);
            @(negedge CLK);
        end
        repeat (6) @(negedge CLK);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/gray_ptr_sync_mon.md
Name: gray_ptr_sync_mon

Overview:
- Parametrised successor to the FIFO pointer synchroniser.
- Carries a Gray-coded pointer from a foreign clock domain through a configurable N-flop synchroniser chain.
- Adds a registered monitor stage with Gray-to-binary conversion, an update pulse, a modular step count and a sticky Gray-integrity error.
- Sits in the async FIFO wrapper on both read and write sides; feeds full/empty logic and occupancy counters.

Parameters:
- ADDRSIZE, 4, pointer address bits; the pointer is ADDRSIZE+1 bits wide (includes the wrap bit).
- STAGES, 2, synchroniser depth; legal range 2..4. Values outside this range are a compile-time error via a generate-time check.
- CHECK_EN, 1, 1 enables Gray-integrity checking; 0 ties err to 0.

Ports:
- CLK  input  1  destination-domain clock.
- RST  input  1  asynchronous, active-high reset.
- ptr  input  ADDRSIZE+1  Gray-coded pointer from the source domain; asynchronous to CLK.
- err_clr  input  1  synchronous clear of the sticky err flag.
- q_ptr  output  ADDRSIZE+1  synchronised Gray pointer (last synchroniser flop).
- q_bin  output  ADDRSIZE+1  registered binary equivalent of q_ptr.
- upd  output  1  one-cycle pulse: synchronised pointer changed.
- step  output  ADDRSIZE+1  binary distance moved, modulo 2^(ADDRSIZE+1).
- err  output  1  sticky: a synchronised change flipped more than one bit.

Behaviour:
- Reset
  - RST high asynchronously clears every flop: sync chain, q_bin, previous-value register, upd, step, err.
  - All outputs read 0 while RST is high and on the first edge after release.
- Sync chain
  - Shift register of STAGES flops, each ADDRSIZE+1 bits wide; ptr enters stage 0.
  - No logic between stages.
  - q_ptr is the last stage output.
  - Latency: a ptr value stable before edge k appears on q_ptr after edge k+STAGES-1.
- Monitor stage: one additional register stage, updated every edge.
  - prev <= q_ptr.
  - q_bin <= gray2bin(q_ptr), where b[MSB]=g[MSB] and b[i]=b[i+1]^g[i].
  - upd <= (q_ptr != prev).
  - step <= gray2bin(q_ptr) - gray2bin(prev), truncated to ADDRSIZE+1 bits. This gives a natural wrap: 31->0 gives step=1.
  - When upd=0, step=0.
  - q_bin, upd, step and err lag q_ptr by exactly one cycle.
- Gray integrity
  - If CHECK_EN=1 and popcount(q_ptr ^ prev) > 1, err is set on the next edge.
  - err stays set until an edge with err_clr=1 and no new violation on that edge.
  - Simultaneous err_clr and violation: set wins; err remains 1.
  - err_clr while err=0 has no effect.
- Reset mid-operation
  - Immediate clear of all state.
  - The chain refills from ptr after release.
  - The first nonzero value reaching q_ptr after release produces upd=1, step equal to its binary value, and a possible err if it differs from 0 in more than one bit.
  - Firmware clears err after a reset if required.
- No handshake with the source domain; the source must change ptr by at most one Gray bit per source clock.

Test Plan:
- Reset: assert RST with ptr=5'b10110 for 3 cycles -> q_ptr=0, q_bin=0, upd=0, step=0, err=0 throughout; the async clear is observed before any CLK edge.
- Latency (STAGES=2): after reset, ptr=5'b00001 held -> q_ptr=00001 after 2nd edge; q_bin=1, upd=1, step=1 after 3rd edge; upd=0, step=0 on 4th edge.
- Full Gray count with wrap: drive Gray 0..31 then 0, one value per cycle -> upd high continuously, step=1 every cycle including the 10000->00000 wrap, q_bin tracks 0..31,0, err=0.
- Multi-bit jump: from q_ptr=00000 force ptr=00011 -> next monitor edge gives q_bin=2, step=2, upd=1, err=1. err stays 1 for 10 idle cycles. err_clr pulse -> err=0 next edge.
- Clear/violation collision: drive err_clr=1 on the same edge a second jump 00011->01100 is registered -> err remains 1. With CHECK_EN=0, the same jump leaves err=0.
- Depth/reset mid-run (STAGES=3): q_ptr lags ptr by 3 edges. Assert RST during a count at value 9 -> all outputs 0 immediately. After release with ptr=Gray(9)=01101 -> upd=1, step=9, err=1.
